dac_scan_spi: RTL

//  Parametrised multi-channel DAC refresh engine. Each sweep walks the enabled channels in ascending index,

---
 rtl/dac_scan_spi.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dac_scan_spi.sv
// ============================================================================
// Module  : dac_scan_spi
// Purpose : Multi-channel DAC refresh engine; walks enabled channels in
//           ascending order and shifts each snapshot code out as an SPI frame.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module dac_scan_spi #(
    parameter int N_CH    = 8,
    parameter int DATA_W  = 12,
    parameter int FRAME_W = 16,
    parameter int ADDR_EN = 0,
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8,
    localparam int CH_W   = $clog2(N_CH)
) (
    input  logic                     i_clk_core,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic                     i_mode,
    input  logic [N_CH-1:0]          i_ch_mask,
    input  logic [N_CH*DATA_W-1:0]   i_data_in,
    output logic                     o_sclk,
    output logic                     o_dout,
    output logic                     o_sync_n,
    output logic [CH_W-1:0]          o_pos,
    output logic                     o_busy,
    output logic                     o_sweep_done
);

    localparam int PTR_W = CH_W + 1;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(FRAME_W + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_en_d;
    logic [N_CH-1:0]      r_mask;
    logic                 r_mode;
    logic [PTR_W-1:0]     r_ptr;
    logic [CH_W-1:0]      r_ch;
    logic [FRAME_W-1:0]   r_frame;
    logic [DIV_W-1:0]     r_div;
    logic [BIT_W-1:0]     r_bit;
    logic [GAP_W-1:0]     r_gap;
    logic                 r_sclk_i;
    logic                 r_sclk;
    logic                 r_dout;
    logic                 r_sync_n;
    logic [CH_W-1:0]      r_pos;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_start;
    logic                 w_restart;
    logic                 w_div_wrap;
    logic                 w_last_bit;
    logic                 w_shift_end;
    logic                 w_gap_end;
    logic                 w_found;
    logic [CH_W-1:0]      w_ch;
    logic [DATA_W-1:0]    w_code;
    logic [FRAME_W-1:0]   w_frame;

    assign w_start     = i_en && (i_mode || !r_en_d) && (i_ch_mask != '0);
    assign w_restart   = r_mode && i_en && (i_ch_mask != '0);
    assign w_div_wrap  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_bit  = (r_bit == BIT_W'(FRAME_W - 1));
    assign w_shift_end = w_div_wrap && !r_sclk_i && w_last_bit;
    assign w_gap_end   = (r_gap == GAP_W'(GAP_CYC - 1));

    // Lowest enabled channel at or above the scan pointer; descending loop lets the lowest win.
    always_comb begin
        w_found = 1'b0;
        w_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && (PTR_W'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_ch    = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_code = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (CH_W'(i) == w_ch) begin
                w_code = i_data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    if (ADDR_EN != 0) begin : g_addr
        always_comb begin
            w_frame                     = '0;
            w_frame[DATA_W-1:0]         = w_code;
            w_frame[DATA_W +: CH_W]     = w_ch;
        end
    end else begin : g_noaddr
        always_comb begin
            w_frame             = '0;
            w_frame[DATA_W-1:0] = w_code;
        end
    end

    always_ff @(posedge i_clk_core) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_shift_end) w_state_nxt = S_GAP;
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = (w_found || w_restart) ? S_LOAD : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pin outputs are registered from the state, so they trail the internal sequencing by one cycle.
    always_ff @(posedge i_clk_core) begin
        if (i_rst) begin
            r_en_d   <= 1'b0;
            r_mask   <= '0;
            r_mode   <= 1'b0;
            r_ptr    <= '0;
            r_ch     <= '0;
            r_frame  <= '0;
            r_div    <= '0;
            r_bit    <= '0;
            r_gap    <= '0;
            r_sclk_i <= 1'b1;
            r_sclk   <= 1'b1;
            r_dout   <= 1'b0;
            r_sync_n <= 1'b1;
            r_pos    <= CH_W'(N_CH - 1);
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_en_d   <= i_en;
            r_done   <= 1'b0;
            r_sclk   <= (r_state == S_SHIFT) ? r_sclk_i : 1'b1;
            r_sync_n <= (r_state != S_SHIFT);
            r_dout   <= (r_state == S_SHIFT) ? r_frame[FRAME_W-1] : 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_start) begin
                        r_mask <= i_ch_mask;
                        r_mode <= i_mode;
                        r_ptr  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_ch     <= w_ch;
                    r_ptr    <= PTR_W'(w_ch) + PTR_W'(1);
                    r_frame  <= w_frame;
                    r_div    <= '0;
                    r_bit    <= '0;
                    r_sclk_i <= 1'b1;
                end
                S_SHIFT: begin
                    if (w_div_wrap) begin
                        r_div    <= '0;
                        r_sclk_i <= !r_sclk_i;
                        if (!r_sclk_i) begin
                            if (w_last_bit) begin
                                r_pos <= r_ch;
                                r_gap <= '0;
                            end else begin
                                r_bit   <= r_bit + BIT_W'(1);
                                r_frame <= {r_frame[FRAME_W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + GAP_W'(1);
                    if (w_gap_end && !w_found) begin
                        r_done <= 1'b1;
                        if (w_restart) begin
                            r_mask <= i_ch_mask;
                            r_ptr  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sclk       = r_sclk;
    assign o_dout       = r_dout;
    assign o_sync_n     = r_sync_n;
    assign o_pos        = r_pos;
    assign o_busy       = r_busy;
    assign o_sweep_done = r_done;

endmodule

`default_nettype wire
